exe_stage_unit: RTL

//  Execute stage placed directly downstream of the ID/EXE pipeline register.
//  - Consumes the decoded control and operand fields latched by that register.
//  - Computes Val2 (immediate rotate, register shift or memory offset), the ALU

---
 rtl/arm_pkg.sv | 39 +++
 rtl/val2_generate.sv | 52 +++++
 rtl/exe_stage_unit.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/arm_pkg.sv
// Shared encodings for the execute stage: ALU commands, shifter types,
// forwarding selects and status-flag bit positions.
package arm_pkg;

    // ALU command encodings driven by the decoder
    typedef enum logic [3:0] {
        CmdMov = 4'b0001,
        CmdAdd = 4'b0010,
        CmdAdc = 4'b0011,
        CmdSub = 4'b0100,
        CmdSbc = 4'b0101,
        CmdAnd = 4'b0110,
        CmdOrr = 4'b0111,
        CmdEor = 4'b1000,
        CmdMvn = 4'b1001
    } exe_cmd_e;

    // Register-shift type field so[6:5]
    typedef enum logic [1:0] {
        ShLsl = 2'b00,
        ShLsr = 2'b01,
        ShAsr = 2'b10,
        ShRor = 2'b11
    } shift_type_e;

    // Operand forwarding select; 2'b11 is treated as FwdId
    typedef enum logic [1:0] {
        FwdId  = 2'b00,
        FwdMem = 2'b01,
        FwdWb  = 2'b10
    } fwd_sel_e;

    // Bit positions inside the {N,Z,C,V} status nibble
    localparam int unsigned FlagN = 3;
    localparam int unsigned FlagZ = 2;
    localparam int unsigned FlagC = 1;
    localparam int unsigned FlagV = 0;

endpackage

// File: rtl/val2_generate.sv
// Second-operand (Val2) generator for the execute stage.
// Ports:
//   mem_en_i          load or store: Val2 is the zero-extended 12-bit offset
//   imm_i             immediate operand: 8-bit value rotated right by 2*rot
//   shift_operand_i   12-bit shifter operand field
//   rm_i              forwarded Rm value for register shifts
//   val2_o            resulting second operand
module val2_generate
    import arm_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              mem_en_i,
    input  logic              imm_i,
    input  logic [11:0]       shift_operand_i,
    input  logic [DATA_W-1:0] rm_i,
    output logic [DATA_W-1:0] val2_o
);

    logic [DATA_W-1:0] imm_ext;
    logic [4:0]        rot_amt;
    logic [4:0]        sh_amt;
    shift_type_e       sh_type;

    always_comb begin
        imm_ext = DATA_W'(shift_operand_i[7:0]);
        rot_amt = {shift_operand_i[11:8], 1'b0};
        sh_amt  = shift_operand_i[11:7];
        sh_type = shift_type_e'(shift_operand_i[6:5]);
        val2_o  = rm_i;

        if (mem_en_i) begin
            val2_o = DATA_W'(shift_operand_i);
        end else if (imm_i) begin
            // Guard the zero rotate: a shift by DATA_W would clear the value
            if (rot_amt == 5'd0) begin
                val2_o = imm_ext;
            end else begin
                val2_o = (imm_ext >> rot_amt) | (imm_ext << (DATA_W - 32'(rot_amt)));
            end
        end else if (sh_amt != 5'd0) begin
            unique case (sh_type)
                ShLsl: val2_o = rm_i << sh_amt;
                ShLsr: val2_o = rm_i >> sh_amt;
                ShAsr: val2_o = DATA_W'($signed(rm_i) >>> sh_amt);
                ShRor: val2_o = (rm_i >> sh_amt) | (rm_i << (DATA_W - 32'(sh_amt)));
                default: val2_o = rm_i;
            endcase
        end
    end

endmodule

// File: rtl/exe_stage_unit.sv
// Execute stage: operand forwarding, Val2 generation, ALU, NZCV flags,
// the architectural status register and the EXE/MEM pipeline register.
// Ports:
//   clk, rst (async active-low), freeze (holds EXE/MEM and status)
//   *_IN            decoded control/operands from the ID/EXE register
//   Status_in       {N,Z,C,V} captured at decode, carry source for ADC/SBC
//   sel_src1/2      forwarding selects, mem_fwd_val / wb_fwd_val sources
//   branch_taken, branch_addr   same-cycle branch outputs
//   status          status register to the ID condition check
//   WB_EN, MEM_R_EN, MEM_W_EN, ALU_Res, Val_Rm, Dest   EXE/MEM register
module exe_stage_unit
    import arm_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              WB_EN_IN,
    input  logic              MEM_R_EN_IN,
    input  logic              MEM_W_EN_IN,
    input  logic              B_IN,
    input  logic              S_IN,
    input  logic [3:0]        EXE_CMD_IN,
    input  logic [DATA_W-1:0] PC_IN,
    input  logic [DATA_W-1:0] Val_Rn_IN,
    input  logic [DATA_W-1:0] Val_Rm_IN,
    input  logic              imm_IN,
    input  logic [11:0]       Shift_operand_IN,
    input  logic [23:0]       Signed_imm_24_IN,
    input  logic [REG_AW-1:0] Dest_IN,
    input  logic [3:0]        Status_in,
    input  logic [1:0]        sel_src1,
    input  logic [1:0]        sel_src2,
    input  logic [DATA_W-1:0] mem_fwd_val,
    input  logic [DATA_W-1:0] wb_fwd_val,
    output logic              branch_taken,
    output logic [DATA_W-1:0] branch_addr,
    output logic [3:0]        status,
    output logic              WB_EN,
    output logic              MEM_R_EN,
    output logic              MEM_W_EN,
    output logic [DATA_W-1:0] ALU_Res,
    output logic [DATA_W-1:0] Val_Rm,
    output logic [REG_AW-1:0] Dest
);

    localparam int unsigned Msb = DATA_W - 1;

    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] rm;
    logic [DATA_W-1:0] val2;
    logic [DATA_W-1:0] add_b;
    logic              add_cin;
    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] alu_res;
    logic              cmd_valid;
    logic              cmd_arith;
    logic [3:0]        flags_new;

    logic [3:0]        status_d, status_q;
    logic              wb_en_d, wb_en_q;
    logic              mem_r_en_d, mem_r_en_q;
    logic              mem_w_en_d, mem_w_en_q;
    logic [DATA_W-1:0] alu_res_d, alu_res_q;
    logic [DATA_W-1:0] val_rm_d, val_rm_q;
    logic [REG_AW-1:0] dest_d, dest_q;

    // Forwarding muxes; the unused code 2'b11 falls back to the ID value
    always_comb begin
        unique case (sel_src1)
            FwdMem:  op1 = mem_fwd_val;
            FwdWb:   op1 = wb_fwd_val;
            default: op1 = Val_Rn_IN;
        endcase
        unique case (sel_src2)
            FwdMem:  rm = mem_fwd_val;
            FwdWb:   rm = wb_fwd_val;
            default: rm = Val_Rm_IN;
        endcase
    end

    val2_generate #(
        .DATA_W (DATA_W)
    ) u_val2_generate (
        .mem_en_i        (MEM_R_EN_IN | MEM_W_EN_IN),
        .imm_i           (imm_IN),
        .shift_operand_i (Shift_operand_IN),
        .rm_i            (rm),
        .val2_o          (val2)
    );

    // Subtraction reuses the adder as op1 + ~val2 + cin, so the adder
    // carry-out is directly the NOT-borrow C flag.
    always_comb begin
        add_b     = val2;
        add_cin   = 1'b0;
        cmd_valid = 1'b1;
        cmd_arith = 1'b0;
        alu_res   = '0;

        unique case (EXE_CMD_IN)
            CmdAdd: begin
                cmd_arith = 1'b1;
            end
            CmdAdc: begin
                cmd_arith = 1'b1;
                add_cin   = Status_in[FlagC];
            end
            CmdSub: begin
                cmd_arith = 1'b1;
                add_b     = ~val2;
                add_cin   = 1'b1;
            end
            CmdSbc: begin
                cmd_arith = 1'b1;
                add_b     = ~val2;
                add_cin   = Status_in[FlagC];
            end
            CmdMov, CmdMvn, CmdAnd, CmdOrr, CmdEor: ;
            default: cmd_valid = 1'b0;
        endcase

        sum = {1'b0, op1} + {1'b0, add_b} + {{DATA_W{1'b0}}, add_cin};

        unique case (EXE_CMD_IN)
            CmdMov:                         alu_res = val2;
            CmdMvn:                         alu_res = ~val2;
            CmdAdd, CmdAdc, CmdSub, CmdSbc: alu_res = sum[DATA_W-1:0];
            CmdAnd:                         alu_res = op1 & val2;
            CmdOrr:                         alu_res = op1 | val2;
            CmdEor:                         alu_res = op1 ^ val2;
            default:                        alu_res = '0;
        endcase

        flags_new = Status_in;
        flags_new[FlagN] = alu_res[Msb];
        flags_new[FlagZ] = (alu_res == '0);
        if (cmd_arith) begin
            flags_new[FlagC] = sum[DATA_W];
            flags_new[FlagV] = (op1[Msb] == add_b[Msb]) && (alu_res[Msb] != op1[Msb]);
        end
    end

    // Unknown commands leave the status register untouched even with S set
    always_comb begin
        status_d   = status_q;
        wb_en_d    = wb_en_q;
        mem_r_en_d = mem_r_en_q;
        mem_w_en_d = mem_w_en_q;
        alu_res_d  = alu_res_q;
        val_rm_d   = val_rm_q;
        dest_d     = dest_q;
        if (!freeze) begin
            if (S_IN && cmd_valid) begin
                status_d = flags_new;
            end
            wb_en_d    = WB_EN_IN;
            mem_r_en_d = MEM_R_EN_IN;
            mem_w_en_d = MEM_W_EN_IN;
            alu_res_d  = alu_res;
            val_rm_d   = rm;
            dest_d     = Dest_IN;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            status_q   <= '0;
            wb_en_q    <= 1'b0;
            mem_r_en_q <= 1'b0;
            mem_w_en_q <= 1'b0;
            alu_res_q  <= '0;
            val_rm_q   <= '0;
            dest_q     <= '0;
        end else begin
            status_q   <= status_d;
            wb_en_q    <= wb_en_d;
            mem_r_en_q <= mem_r_en_d;
            mem_w_en_q <= mem_w_en_d;
            alu_res_q  <= alu_res_d;
            val_rm_q   <= val_rm_d;
            dest_q     <= dest_d;
        end
    end

    assign branch_taken = B_IN;
    assign branch_addr  = PC_IN + {{(DATA_W - 26){Signed_imm_24_IN[23]}}, Signed_imm_24_IN, 2'b00};

    assign status   = status_q;
    assign WB_EN    = wb_en_q;
    assign MEM_R_EN = mem_r_en_q;
    assign MEM_W_EN = mem_w_en_q;
    assign ALU_Res  = alu_res_q;
    assign Val_Rm   = val_rm_q;
    assign Dest     = dest_q;

endmodule
